// File: rtl/block_mem.sv
// Block-granular memory responder for the cache miss/write-back port: one whole-block
// access at a time, fixed latency, one-cycle done pulse. Optional error pulse: BLOCK_MEM_ERR_EN.
module block_mem #(
    parameter int line_size    = 32,
    parameter int block_size   = 2,
    parameter int address_size = 32,
    parameter int mem_depth    = 8,
    parameter int latency      = 4,
    localparam int BW = (2 ** block_size) * line_size,
    localparam int AW = address_size - block_size - 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          m_read_i,
    input  logic          m_wr_i,
    input  logic [AW-1:0] m_address_i,
    input  logic [BW-1:0] m_write_data_i,
    output logic [BW-1:0] m_read_data_o,
    output logic          m_busywait_o,
    output logic          m_read_done_o,
`ifdef BLOCK_MEM_ERR_EN
    output logic          m_err_o,
`endif
    output logic          m_write_done_o
);

    localparam logic [3:0] CNT_LOAD = 4'(latency - 1);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [mem_depth-1:0] r_idx;
    logic [BW-1:0]        r_wdata;
    logic [BW-1:0]        r_rdata;
    logic                 r_busy;
    logic                 r_rdone;
    logic                 r_wdone;
    logic [BW-1:0]        r_mem [2**mem_depth];

    logic w_accept;
    logic w_rd_commit;
    logic w_wr_commit;
    logic w_addr_hi;

    assign w_accept    = (r_state == IDLE) && (m_wr_i || m_read_i);
    assign w_rd_commit = (r_state == READ_WAIT) && (r_cnt == 4'd0);
    assign w_wr_commit = (r_state == WRITE_WAIT) && (r_cnt == 4'd0);
    assign w_addr_hi   = |m_address_i[AW-1:mem_depth];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // Write wins over a simultaneous read; the read is simply not accepted.
                if (m_wr_i)
                    w_state_nxt = WRITE_WAIT;
                else if (m_read_i)
                    w_state_nxt = READ_WAIT;
            end
            READ_WAIT:  if (r_cnt == 4'd0) w_state_nxt = DONE;
            WRITE_WAIT: if (r_cnt == 4'd0) w_state_nxt = DONE;
            DONE:       w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_rdone <= 1'b0;
            r_wdone <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= CNT_LOAD;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            r_busy  <= (w_state_nxt == READ_WAIT) || (w_state_nxt == WRITE_WAIT);
            r_rdone <= w_rd_commit;
            r_wdone <= w_wr_commit;
            if (w_rd_commit)
                r_rdata <= r_mem[r_idx];
        end
    end

    // Upper address bits alias onto the stored blocks, so only the index is kept.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_idx   <= m_address_i[mem_depth-1:0];
            r_wdata <= m_write_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_commit)
            r_mem[r_idx] <= r_wdata;
    end

    assign m_read_data_o  = r_rdata;
    assign m_busywait_o   = r_busy;
    assign m_read_done_o  = r_rdone;
    assign m_write_done_o = r_wdone;

`ifdef BLOCK_MEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_err <= 1'b0;
        else
            r_err <= w_accept && ((m_read_i && m_wr_i) || w_addr_hi);
    end

    assign m_err_o = r_err;
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = w_addr_hi;
`endif

endmodule

// File: tb/tb_block_mem.sv
// Self-checking bench for block_mem: a latency-4 and a latency-1 instance checked
// against an array model of block storage and the request/done timing rules.
module tb_block_mem;

    localparam int BW = 128;
    localparam int AW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          rd    [2];
    logic          wr    [2];
    logic [AW-1:0] addr  [2];
    logic [BW-1:0] wdata [2];
    logic [BW-1:0] rdata [2];
    logic          busy  [2];
    logic          rdone [2];
    logic          wdone [2];
    logic          err   [2];

    block_mem #(.latency(4)) u_dut0 (
        .clk_i(clk), .reset_i(reset_n),
        .m_read_i(rd[0]), .m_wr_i(wr[0]), .m_address_i(addr[0]),
        .m_write_data_i(wdata[0]), .m_read_data_o(rdata[0]),
        .m_busywait_o(busy[0]), .m_read_done_o(rdone[0]),
`ifdef BLOCK_MEM_ERR_EN
        .m_err_o(err[0]),
`endif
        .m_write_done_o(wdone[0])
    );

    block_mem #(.latency(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset_n),
        .m_read_i(rd[1]), .m_wr_i(wr[1]), .m_address_i(addr[1]),
        .m_write_data_i(wdata[1]), .m_read_data_o(rdata[1]),
        .m_busywait_o(busy[1]), .m_read_done_o(rdone[1]),
`ifdef BLOCK_MEM_ERR_EN
        .m_err_o(err[1]),
`endif
        .m_write_done_o(wdone[1])
    );

`ifndef BLOCK_MEM_ERR_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] model [2][256];
    bit            valid [2][256];
    int            lat   [2] = '{4, 1};

    // Access results
    int            nbusy, acc_delay;
    bit            got_rd, got_wr, overlap, errs, post_done, post_busy, tmo;
    logic [BW-1:0] rd_data;

    function automatic logic [BW-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Requester: called at a negedge; returns at the negedge of the cycle after done.
    task automatic do_access(input int s, input bit is_rd, input bit is_wr,
                             input logic [AW-1:0] a, input logic [BW-1:0] d, input bit hold);
        rd[s] = is_rd; wr[s] = is_wr; addr[s] = a; wdata[s] = d;
        nbusy = 0; acc_delay = -1; got_rd = 0; got_wr = 0; overlap = 0; errs = 0;
        tmo = 1; rd_data = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy[s]) begin
                nbusy++;
                if (acc_delay < 0) acc_delay = i;
            end
            if (busy[s] && (rdone[s] || wdone[s])) overlap = 1;
            if (err[s]) errs = 1;
            if (!busy[s] && (rdone[s] || wdone[s])) begin
                got_rd = rdone[s]; got_wr = wdone[s]; rd_data = rdata[s]; tmo = 0;
                break;
            end
        end
        if (!hold) begin rd[s] = 0; wr[s] = 0; end
        @(negedge clk);
        post_done = rdone[s] | wdone[s];
        post_busy = busy[s];
        rd[s] = 0; wr[s] = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 0; wr[s] = 0; addr[s] = '0; wdata[s] = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({busy[s], rdone[s], wdone[s], err[s]} !== 4'b0 || rdata[s] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: busy=%b rdone=%b wdone=%b err=%b rdata=%h, want all 0",
                         s, busy[s], rdone[s], wdone[s], err[s], rdata[s]);
            end
        end
        reset_n = 1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b want 0", busy[0]);
        end
    endtask

    task automatic test_write_read();
        logic [BW-1:0] d;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_access(0, 0, 1, 28'h05, d, 0);
        model[0][8'h05] = d; valid[0][8'h05] = 1;
        checks++;
        if (tmo || nbusy != 4 || !got_wr || got_rd || overlap || post_done) begin
            errors++;
            $display("FAIL write_05: tmo=%0b busy_cycles=%0d wdone=%0b rdone=%0b overlap=%0b post=%0b, want 0 4 1 0 0 0",
                     tmo, nbusy, got_wr, got_rd, overlap, post_done);
        end
        do_access(0, 1, 0, 28'h05, '0, 0);
        checks++;
        if (tmo || nbusy != 4 || !got_rd || got_wr || overlap || post_done) begin
            errors++;
            $display("FAIL read_05_timing: tmo=%0b busy_cycles=%0d rdone=%0b wdone=%0b overlap=%0b post=%0b, want 0 4 1 0 0 0",
                     tmo, nbusy, got_rd, got_wr, overlap, post_done);
        end
        checks++;
        if (rd_data !== d) begin
            errors++; $display("FAIL read_05_data: got %h want %h", rd_data, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] a_d, b_d;
        a_d = rand_blk(); b_d = rand_blk();
        do_access(0, 0, 1, 28'h20, b_d, 0);
        model[0][8'h20] = b_d; valid[0][8'h20] = 1;
        do_access(0, 0, 1, 28'h10, a_d, 0);
        model[0][8'h10] = a_d; valid[0][8'h10] = 1;
        do_access(0, 1, 0, 28'h20, '0, 0);
        checks++;
        if (tmo || acc_delay != 1 || !got_rd) begin
            errors++;
            $display("FAIL refill_accept: tmo=%0b accept_delay=%0d rdone=%0b, want 0 1 1", tmo, acc_delay, got_rd);
        end
        checks++;
        if (rd_data !== model[0][8'h20]) begin
            errors++; $display("FAIL refill_data: got %h want %h", rd_data, model[0][8'h20]);
        end
        do_access(0, 1, 0, 28'h10, '0, 0);
        checks++;
        if (tmo || rd_data !== model[0][8'h10]) begin
            errors++; $display("FAIL writeback_data: tmo=%0b got %h want %h", tmo, rd_data, model[0][8'h10]);
        end
    endtask

    task automatic test_both_requests();
        logic [BW-1:0] d;
        d = rand_blk();
        do_access(0, 1, 1, 28'h07, d, 0);
        model[0][8'h07] = d; valid[0][8'h07] = 1;
        checks++;
        if (tmo || !got_wr || got_rd || post_done) begin
            errors++;
            $display("FAIL both_req: tmo=%0b wdone=%0b rdone=%0b post=%0b, want 0 1 0 0", tmo, got_wr, got_rd, post_done);
        end
`ifdef BLOCK_MEM_ERR_EN
        checks++;
        if (errs !== 1'b1) begin
            errors++; $display("FAIL both_req_err: err=%0b want 1", errs);
        end
`endif
        do_access(0, 1, 0, 28'h07, '0, 0);
        checks++;
        if (rd_data !== d) begin
            errors++; $display("FAIL both_req_data: got %h want %h", rd_data, d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [BW-1:0] old_d, new_d;
        old_d = rand_blk(); new_d = ~old_d;
        do_access(0, 0, 1, 28'h09, old_d, 0);
        model[0][8'h09] = old_d; valid[0][8'h09] = 1;
        rd[0] = 0; wr[0] = 1; addr[0] = 28'h09; wdata[0] = new_d;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        checks++;
        if ({busy[0], rdone[0], wdone[0], err[0]} !== 4'b0 || rdata[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b rdone=%b wdone=%b err=%b rdata=%h, want all 0",
                     busy[0], rdone[0], wdone[0], err[0], rdata[0]);
        end
        @(negedge clk);
        wr[0] = 0;
        reset_n = 1;
        @(negedge clk);
        do_access(0, 1, 0, 28'h09, '0, 0);
        checks++;
        if (tmo || nbusy != 4 || rd_data !== old_d) begin
            errors++;
            $display("FAIL reset_mid_keep: tmo=%0b busy_cycles=%0d got %h want %h", tmo, nbusy, rd_data, old_d);
        end
    endtask

    task automatic test_latency1();
        logic [BW-1:0] d;
        d = rand_blk();
        do_access(1, 0, 1, 28'h33, d, 0);
        model[1][8'h33] = d; valid[1][8'h33] = 1;
        do_access(1, 1, 0, 28'h33, '0, 1);
        checks++;
        if (tmo || nbusy != 1 || acc_delay != 1 || !got_rd) begin
            errors++;
            $display("FAIL lat1_timing: tmo=%0b busy_cycles=%0d accept_delay=%0d rdone=%0b, want 0 1 1 1",
                     tmo, nbusy, acc_delay, got_rd);
        end
        checks++;
        if (post_busy || post_done) begin
            errors++; $display("FAIL lat1_hold: busy=%0b done=%0b after DONE, want 0 0", post_busy, post_done);
        end
        checks++;
        if (rd_data !== d) begin
            errors++; $display("FAIL lat1_data: got %h want %h", rd_data, d);
        end
    endtask

    task automatic test_alias();
        do_access(0, 1, 0, 28'h105, '0, 0);
        checks++;
        if (tmo || rd_data !== model[0][8'h05]) begin
            errors++; $display("FAIL alias_data: tmo=%0b got %h want %h", tmo, rd_data, model[0][8'h05]);
        end
`ifdef BLOCK_MEM_ERR_EN
        checks++;
        if (errs !== 1'b1) begin
            errors++; $display("FAIL alias_err: err=%0b want 1", errs);
        end
`endif
    endtask

    task automatic test_random();
        logic [BW-1:0] last_rd [2];
        bit            lr_vld  [2];
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        int            s;
        bit            do_wr;
        lr_vld[0] = 0; lr_vld[1] = 0;
        for (int n = 0; n < 40; n++) begin
            s = $urandom_range(0, 1);
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a[AW-1:8] = 20'($urandom);
            do_wr = ($urandom_range(0, 1) == 1) || !valid[s][a[7:0]];
            d = rand_blk();
            do_access(s, !do_wr, do_wr, a, d, 0);
            checks++;
            if (tmo || nbusy != lat[s] || got_wr != do_wr || got_rd == do_wr || overlap || post_done) begin
                errors++;
                $display("FAIL rand_timing #%0d dut%0d: tmo=%0b busy_cycles=%0d wdone=%0b rdone=%0b overlap=%0b post=%0b, want busy %0d wr %0b",
                         n, s, tmo, nbusy, got_wr, got_rd, overlap, post_done, lat[s], do_wr);
            end
`ifdef BLOCK_MEM_ERR_EN
            checks++;
            if (errs != (a[AW-1:8] != 0)) begin
                errors++; $display("FAIL rand_err #%0d: err=%0b addr=%h", n, errs, a);
            end
`endif
            if (do_wr) begin
                model[s][a[7:0]] = d; valid[s][a[7:0]] = 1;
                if (lr_vld[s]) begin
                    checks++;
                    if (rdata[s] !== last_rd[s]) begin
                        errors++; $display("FAIL rand_rdata_hold #%0d: got %h want %h", n, rdata[s], last_rd[s]);
                    end
                end
            end else begin
                checks++;
                if (rd_data !== model[s][a[7:0]]) begin
                    errors++;
                    $display("FAIL rand_read #%0d dut%0d addr=%h: got %h want %h", n, s, a, rd_data, model[s][a[7:0]]);
                end
                last_rd[s] = model[s][a[7:0]]; lr_vld[s] = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_both_requests();
        test_reset_mid_write();
        test_latency1();
        test_alias();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
